// File: rtl/icache_refill_ctrl_pkg.sv
// Shared I-cache geometry, fetch-address layout and refill FSM state encoding
// for the I-cache refill controller.
package icache_refill_ctrl_pkg;

  localparam int ICACHE_NUM_WAYS      = 2;
  localparam int ICACHE_LINE_WORDS    = 8;
  localparam int ICACHE_NUM_WORD_BITS = $clog2(ICACHE_LINE_WORDS);
  localparam int ICACHE_NUM_SET_BITS  = 6;
  localparam int ICACHE_NUM_TAG_BITS  = 32 - ICACHE_NUM_SET_BITS - ICACHE_NUM_WORD_BITS - 2;

  typedef struct packed {
    logic [ICACHE_NUM_TAG_BITS-1:0]  tag;
    logic [ICACHE_NUM_SET_BITS-1:0]  set_idx;
    logic [ICACHE_NUM_WORD_BITS-1:0] word;
    logic [1:0]                      boff;
  } ifu_address_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_TAG,
    ST_RESUME
  } refill_state_e;

endpackage

// File: rtl/icache_victim_rr.sv
// Global round-robin victim way pointer; advances once per accepted miss.
module icache_victim_rr #(
  parameter int NUM_WAYS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_advance,
  output logic [$clog2(NUM_WAYS)-1:0] o_way
);

  localparam int WAY_BITS = $clog2(NUM_WAYS);

  logic [WAY_BITS-1:0] r_ptr;

  // NUM_WAYS is a power of two, so natural wrap gives the modulo.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= r_ptr + WAY_BITS'(1);
    end
  end

  assign o_way = r_ptr;

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill controller: burst read, data-RAM fill, tag update, fetch restart.
// Optional ICACHE_CRITICAL_WORD_FIRST_EN starts the burst at the missing word.
//
// state     | meaning
// ST_IDLE   | waiting for a miss
// ST_REQ    | burst request held until memory accepts it
// ST_FILL   | writing returned beats into the victim way
// ST_TAG    | one cycle tag write / valid set (suppressed when dropped)
// ST_RESUME | one cycle fetch restart pulse
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int NUM_WAYS   = ICACHE_NUM_WAYS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_valid,
  input  logic [31:0]                     miss_addr,
  input  logic                            wb_icache_invalidate,
  output logic                            mem_rd_req,
  output logic [31:0]                     mem_rd_addr,
  input  logic                            mem_rd_ready,
  input  logic                            mem_rd_valid,
  input  logic [31:0]                     mem_rd_data,
  output logic [NUM_WAYS-1:0]             data_wr_en,
  output logic [ICACHE_NUM_SET_BITS-1:0]  data_wr_set,
  output logic [$clog2(LINE_WORDS)-1:0]   data_wr_word,
  output logic [31:0]                     data_wr_data,
  output logic [NUM_WAYS-1:0]             update_tag_en,
  output logic [ICACHE_NUM_SET_BITS-1:0]  update_tag_set,
  output logic [ICACHE_NUM_TAG_BITS-1:0]  update_tag,
  output logic                            resume_fetch,
  output logic                            busy
);

  localparam int WB       = $clog2(LINE_WORDS);
  localparam int WAY_BITS = $clog2(NUM_WAYS);

  refill_state_e r_state, w_state_nxt;

  logic [ICACHE_NUM_TAG_BITS-1:0] r_tag;
  logic [ICACHE_NUM_SET_BITS-1:0] r_set;
  logic [31:0]                    r_rd_addr;
  logic [WB-1:0]                  r_word;
  logic [WB-1:0]                  r_beats_left;
  logic [WAY_BITS-1:0]            r_way;
  logic                           r_drop;

  ifu_address_t        w_miss;
  logic [WAY_BITS-1:0] w_victim;
  logic [NUM_WAYS-1:0] w_way_oh;
  logic [WB-1:0]       w_start_word;
  logic [31:0]         w_start_addr;
  logic                w_accept;
  logic                w_beat;
  logic                w_inv_window;
  logic                w_unused;

  assign w_miss   = ifu_address_t'(miss_addr);
  assign w_unused = ^{w_miss.word, w_miss.boff};

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign w_start_word = miss_addr[2 +: WB];
  assign w_start_addr = {miss_addr[31:2], 2'b00};
`else
  assign w_start_word = '0;
  assign w_start_addr = {miss_addr[31:WB+2], {(WB+2){1'b0}}};
`endif

  assign w_accept     = (r_state == ST_IDLE) && miss_valid;
  assign w_beat       = (r_state == ST_FILL) && mem_rd_valid;
  assign w_inv_window = (r_state == ST_REQ) || (r_state == ST_FILL) || (r_state == ST_TAG);
  assign w_way_oh     = NUM_WAYS'(1) << r_way;

  icache_victim_rr #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim_rr (
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_accept),
    .o_way     (w_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_set        <= '0;
      r_rd_addr    <= '0;
      r_word       <= '0;
      r_beats_left <= '0;
      r_way        <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tag        <= w_miss.tag;
        r_set        <= w_miss.set_idx;
        r_rd_addr    <= w_start_addr;
        r_word       <= w_start_word;
        r_beats_left <= WB'(LINE_WORDS - 1);
        r_way        <= w_victim;
        r_drop       <= wb_icache_invalidate;
      end else begin
        if (wb_icache_invalidate && w_inv_window) begin
          r_drop <= 1'b1;
        end
        if (w_beat) begin
          r_word       <= r_word + WB'(1);
          r_beats_left <= r_beats_left - WB'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    mem_rd_req     = 1'b0;
    mem_rd_addr    = '0;
    data_wr_en     = '0;
    data_wr_set    = '0;
    data_wr_word   = '0;
    data_wr_data   = '0;
    update_tag_en  = '0;
    update_tag_set = '0;
    update_tag     = '0;
    resume_fetch   = 1'b0;
    busy           = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (miss_valid) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = r_rd_addr;
        if (mem_rd_ready) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (mem_rd_valid) begin
          data_wr_en   = w_way_oh;
          data_wr_set  = r_set;
          data_wr_word = r_word;
          data_wr_data = mem_rd_data;
          if (r_beats_left == '0) w_state_nxt = ST_TAG;
        end
      end
      ST_TAG: begin
        // An invalidate landing in this very cycle must also suppress the tag write.
        if (!(r_drop || wb_icache_invalidate)) update_tag_en = w_way_oh;
        update_tag_set = r_set;
        update_tag     = r_tag;
        w_state_nxt    = ST_RESUME;
      end
      ST_RESUME: begin
        resume_fetch = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: per-cycle vectors (inputs + expected outputs).
module tb_icache_refill_ctrl;

  logic        clk;
  logic        rst;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        wb_icache_invalidate;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ready;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic [1:0]  data_wr_en;
  logic [5:0]  data_wr_set;
  logic [2:0]  data_wr_word;
  logic [31:0] data_wr_data;
  logic [1:0]  update_tag_en;
  logic [5:0]  update_tag_set;
  logic [20:0] update_tag;
  logic        resume_fetch;
  logic        busy;

  icache_refill_ctrl #(.NUM_WAYS(2), .LINE_WORDS(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .miss_valid           (miss_valid),
    .miss_addr            (miss_addr),
    .wb_icache_invalidate (wb_icache_invalidate),
    .mem_rd_req           (mem_rd_req),
    .mem_rd_addr          (mem_rd_addr),
    .mem_rd_ready         (mem_rd_ready),
    .mem_rd_valid         (mem_rd_valid),
    .mem_rd_data          (mem_rd_data),
    .data_wr_en           (data_wr_en),
    .data_wr_set          (data_wr_set),
    .data_wr_word         (data_wr_word),
    .data_wr_data         (data_wr_data),
    .update_tag_en        (update_tag_en),
    .update_tag_set       (update_tag_set),
    .update_tag           (update_tag),
    .resume_fetch         (resume_fetch),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mv;
    logic [31:0] addr;
    logic        inv;
    logic        rdy;
    logic        vld;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic [1:0]  e_wen;
    logic [2:0]  e_word;
    logic [1:0]  e_ten;
    logic        e_res;
    logic        e_busy;
    logic        chk;
  } vec_t;

  int          n_total = 0;
  int          n_pass  = 0;
  int          vec_id  = 0;
  logic [5:0]  g_set;
  logic [20:0] g_tag;
  vec_t        tbl[16];

  function automatic vec_t mk(logic r, logic mv, logic [31:0] ad, logic inv, logic rdy,
                              logic vld, logic [31:0] d, logic ereq, logic [31:0] eaddr,
                              logic [1:0] ewen, logic [2:0] eword, logic [1:0] eten,
                              logic eres, logic ebusy);
    vec_t v;
    v.rst = r;  v.mv = mv; v.addr = ad; v.inv = inv; v.rdy = rdy; v.vld = vld; v.data = d;
    v.e_req = ereq; v.e_addr = eaddr; v.e_wen = ewen; v.e_word = eword; v.e_ten = eten;
    v.e_res = eres; v.e_busy = ebusy; v.chk = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
    else n_pass++;
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rst                  = v.rst;
    miss_valid           = v.mv;
    miss_addr            = v.addr;
    wb_icache_invalidate = v.inv;
    mem_rd_ready         = v.rdy;
    mem_rd_valid         = v.vld;
    mem_rd_data          = v.data;
    #1;
    vec_id++;
    if (v.chk) begin
      chk("mem_rd_req",    vec_id, 32'(mem_rd_req),    32'(v.e_req));
      chk("mem_rd_addr",   vec_id, mem_rd_addr,        v.e_addr);
      chk("data_wr_en",    vec_id, 32'(data_wr_en),    32'(v.e_wen));
      chk("data_wr_word",  vec_id, 32'(data_wr_word),  32'(v.e_word));
      chk("data_wr_data",  vec_id, data_wr_data,       (v.e_wen != 2'b00) ? v.data : 32'h0);
      chk("data_wr_set",   vec_id, 32'(data_wr_set),   (v.e_wen != 2'b00) ? 32'(g_set) : 32'h0);
      chk("update_tag_en", vec_id, 32'(update_tag_en), 32'(v.e_ten));
      chk("resume_fetch",  vec_id, 32'(resume_fetch),  32'(v.e_res));
      chk("busy",          vec_id, 32'(busy),          32'(v.e_busy));
      if (v.e_ten != 2'b00) begin
        chk("update_tag_set", vec_id, 32'(update_tag_set), 32'(g_set));
        chk("update_tag",     vec_id, 32'(update_tag),     32'(g_tag));
      end
    end
  endtask

  function automatic logic [31:0] burst_addr(logic [31:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return {a[31:2], 2'b00};
`else
    return {a[31:5], 5'b00000};
`endif
  endfunction

  function automatic logic [2:0] start_word(logic [31:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return a[4:2];
`else
    return (a[4:2] & 3'b000);
`endif
  endfunction

  task automatic idle_chk(input logic r);
    step(mk(r, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0));
  endtask

  // inv_beat: -2 no invalidate, -1 together with the miss, 0..7 at that beat
  task automatic do_refill(input logic [31:0] addr, input logic [1:0] way,
                           input int stall, input int inv_beat);
    logic [31:0] a;
    logic [2:0]  s;
    logic [1:0]  ten;
    a     = burst_addr(addr);
    s     = start_word(addr);
    g_set = addr[10:5];
    g_tag = addr[31:11];
    ten   = (inv_beat == -2) ? way : 2'b00;
    step(mk(1'b0, 1'b1, addr, inv_beat == -1, 1'b0, 1'b0, '0,
            1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < stall; i++)
      step(mk(1'b0, i == 2, 32'h0000_5678, 1'b0, 1'b0, 1'b0, '0,
              1'b1, a, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1));
    step(mk(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1, a, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1));
    for (int k = 0; k < 8; k++)
      step(mk(1'b0, 1'b0, '0, k == inv_beat, 1'b0, 1'b1, 32'hC0DE_0000 + 32'(k),
              1'b0, '0, way, 3'(s + 3'(k)), 2'b00, 1'b0, 1'b1));
    step(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 3'd0, ten, 1'b0, 1'b1));
    step(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b1, 1'b1));
    idle_chk(1'b0);
  endtask

  initial begin
    logic [31:0] ta;
    logic [2:0]  ts;
    vec_t        vr;

    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; wb_icache_invalidate = 1'b0;
    mem_rd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    repeat (2) @(posedge clk);

    // Basic fill of 0x0000_1234: set 17, tag 2, victim way 0
    g_set = 6'd17;
    g_tag = 21'd2;
    ta = burst_addr(32'h0000_1234);
    ts = start_word(32'h0000_1234);
    tbl[0] = mk(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, '0,
                1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0);
    tbl[2] = mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0000,
                1'b1, ta, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1);
    tbl[3] = mk(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1, ta, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++)
      tbl[(k < 4) ? 4 + k : 5 + k] = mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hD000_0000 + 32'(k),
                                        1'b0, '0, 2'b01, 3'(ts + 3'(k)), 2'b00, 1'b0, 1'b1);
    tbl[8]  = mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 3'd0, 2'b01, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b1, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(tbl[i]);

    // Victim rotation from a fresh pointer: way 0, way 1, way 0
    idle_chk(1'b1);
    do_refill(32'h0000_1234, 2'b01, 0, -2);
    do_refill(32'h0000_4468, 2'b10, 0, -2);
    do_refill(32'h0000_1234, 2'b01, 0, -2);

    // Stalled handshake with an ignored miss; the next victim proves the pointer held
    do_refill(32'hABCD_E0C4, 2'b10, 5, -2);
    do_refill(32'h0000_1234, 2'b01, 0, 3);
    do_refill(32'h0000_4468, 2'b10, 0, -1);

    // Reset at beat 4: following beats are ignored and the pointer restarts at way 0
    ta = burst_addr(32'h0000_4468);
    ts = start_word(32'h0000_4468);
    g_set = 6'd35;
    step(mk(1'b0, 1'b1, 32'h0000_4468, 1'b0, 1'b0, 1'b0, '0,
            1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1, ta, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1));
    for (int k = 0; k < 4; k++)
      step(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hE000_0000 + 32'(k),
              1'b0, '0, 2'b01, 3'(ts + 3'(k)), 2'b00, 1'b0, 1'b1));
    vr = mk(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hE000_0004,
            1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0);
    vr.chk = 1'b0;
    step(vr);
    for (int k = 5; k < 8; k++)
      step(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hE000_0000 + 32'(k),
              1'b0, '0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0));
    do_refill(32'h0000_1234, 2'b01, 0, -2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
